// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous input in clk_in cycles.
// A saturating counter aborts the measurement into OVF instead of wrapping.
module period_meter #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_out,
    output logic                 valid,
    output logic                 overflow
);

    typedef enum logic [1:0] {IDLE, MEASURE, OVF} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s, rise, fall;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hi_q, hi_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= s;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // rise and fall are mutually exclusive, so the fall capture never races the strobe
                if (fall) hi_d = cnt_q;
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                    ovf_d    = 1'b0;
                    cnt_d    = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = OVF;
                    ovf_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            OVF: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: three instances (default, SYNC_STAGES=3, CNT_WIDTH=4)
// share clock, reset and stimulus; each valid strobe is logged with its cycle number.
module tb_period_meter;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic sig_in = 1'b0;

    logic [15:0] a_per, a_hi, b_per, b_hi;
    logic [3:0]  c_per, c_hi;
    logic        a_vld, a_ovf, b_vld, b_ovf, c_vld, c_ovf;

    period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(2)) u_a (
        .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
        .period_out(a_per), .high_out(a_hi), .valid(a_vld), .overflow(a_ovf));
    period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(3)) u_b (
        .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
        .period_out(b_per), .high_out(b_hi), .valid(b_vld), .overflow(b_ovf));
    period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(2)) u_c (
        .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
        .period_out(c_per), .high_out(c_hi), .valid(c_vld), .overflow(c_ovf));

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int per;
        int hi;
        int ovf;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    ev_t qc[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (a_vld) qa.push_back('{cyc, int'(a_per), int'(a_hi), int'(a_ovf)});
        if (b_vld) qb.push_back('{cyc, int'(b_per), int'(b_hi), int'(b_ovf)});
        if (c_vld) qc.push_back('{cyc, int'(c_per), int'(c_hi), int'(c_ovf)});
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        qa.delete(); qb.delete(); qc.delete();
    endtask

    int c0;

    initial begin
        // reset state, checked before any clock edge
        #1;
        chk("rst_per",  a_per, 0);
        chk("rst_hi",   a_hi, 0);
        chk("rst_vld",  a_vld, 0);
        chk("rst_ovf",  a_ovf, 0);

        // 4H/6L x4: first rise arms, then three strobes 10 cycles apart
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4);
            drive(1'b0, 6);
        end
        chk("p46_cnt", qa.size(), 3);
        for (int i = 0; i < qa.size(); i++) begin
            chk($sformatf("p46_per%0d", i), qa[i].per, 10);
            chk($sformatf("p46_hi%0d", i),  qa[i].hi, 4);
            chk($sformatf("p46_ovf%0d", i), qa[i].ovf, 0);
            if (i > 0) chk($sformatf("p46_gap%0d", i), qa[i].cyc - qa[i-1].cyc, 10);
        end
        chk("p46_b_cnt", qb.size(), 3);
        if (qb.size() > 0) chk("p46_b_per", qb[0].per, 10);

        // alternating every cycle: 10 rises -> 9 strobes of 2/1
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 4);
        chk("alt_cnt", qa.size(), 9);
        for (int i = 0; i < qa.size(); i++) begin
            chk($sformatf("alt_per%0d", i), qa[i].per, 2);
            chk($sformatf("alt_hi%0d", i),  qa[i].hi, 1);
            if (i > 0) chk($sformatf("alt_gap%0d", i), qa[i].cyc - qa[i-1].cyc, 2);
        end

        // 4-bit counter saturates into OVF; recovery clears overflow with the strobe
        do_reset();
        drive(1'b1, 3);
        drive(1'b0, 20);
        chk("ovf_set", c_ovf, 1);
        chk("ovf_novld", qc.size(), 0);
        chk("ovf_a_clear", a_ovf, 0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        chk("ovf_rearm_novld", qc.size(), 0);
        chk("ovf_still", c_ovf, 1);
        drive(1'b1, 5);
        chk("ovf_rec_cnt", qc.size(), 1);
        if (qc.size() > 0) begin
            chk("ovf_rec_per", qc[0].per, 10);
            chk("ovf_rec_hi",  qc[0].hi, 5);
            chk("ovf_rec_ovf", qc[0].ovf, 0);
        end
        chk("ovf_after", c_ovf, 0);

        // async reset mid-measurement of a 6H/6L waveform
        do_reset();
        drive(1'b1, 6); drive(1'b0, 6);
        drive(1'b1, 6); drive(1'b0, 6);
        chk("ar_pre_per", a_per, 12);
        chk("ar_pre_hi",  a_hi, 6);
        sig_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #7;
        rst    = 1'b1;
        sig_in = 1'b0;
        #1;
        chk("ar_per", a_per, 0);
        chk("ar_hi",  a_hi, 0);
        chk("ar_vld", a_vld, 0);
        chk("ar_ovf", a_ovf, 0);
        repeat (3) @(posedge clk_in);
        #7 rst = 1'b0;
        @(posedge clk_in);
        #1;
        qa.delete(); qb.delete(); qc.delete();
        drive(1'b0, 3);
        drive(1'b1, 6); drive(1'b0, 6);
        chk("ar_arm_novld", qa.size(), 0);
        drive(1'b1, 6); drive(1'b0, 4);
        chk("ar_cnt", qa.size(), 1);
        if (qa.size() > 0) begin
            chk("ar_post_per", qa[0].per, 12);
            chk("ar_post_hi",  qa[0].hi, 6);
        end

        // sig_in high through reset release: 4-bit instance arms, saturates, never strobes
        rst    = 1'b1;
        sig_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b0;
        qa.delete(); qb.delete(); qc.delete();
        repeat (30) @(posedge clk_in);
        #1;
        chk("hi_novld_a", qa.size(), 0);
        chk("hi_novld_c", qc.size(), 0);
        chk("hi_ovf_c", c_ovf, 1);
        drive(1'b0, 7);
        drive(1'b1, 4);
        chk("hi_arm_novld", qc.size(), 0);
        drive(1'b0, 7);
        drive(1'b1, 4);
        drive(1'b0, 2);
        chk("hi_cnt", qc.size(), 1);
        if (qc.size() > 0) begin
            chk("hi_per", qc[0].per, 11);
            chk("hi_hi",  qc[0].hi, 4);
        end

        // latency: rise first sampled at edge k -> valid at k+SYNC_STAGES
        do_reset();
        drive(1'b1, 3);
        drive(1'b0, 5);
        qa.delete(); qb.delete();
        c0 = cyc;
        drive(1'b1, 6);
        chk("lat_a_cnt", qa.size(), 1);
        chk("lat_b_cnt", qb.size(), 1);
        if (qa.size() > 0) chk("lat_a", qa[0].cyc - c0, 3);
        if (qb.size() > 0) begin
            chk("lat_b", qb[0].cyc - c0, 4);
            chk("lat_b_per", qb[0].per, 8);
            chk("lat_b_hi", qb[0].hi, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
